// File: rtl/bt_cmd_decoder_pkg.sv
// Shared constants and types for the Bluetooth command frame decoder:
// command codes, motion encoding, default header byte and parser states.
package bt_cmd_decoder_pkg;

  localparam logic [7:0] HDR_BYTE_DEF = 8'hA5;

  localparam logic [7:0] CMD_STOP     = 8'h00;
  localparam logic [7:0] CMD_FWD      = 8'h01;
  localparam logic [7:0] CMD_BACK     = 8'h02;
  localparam logic [7:0] CMD_LEFT     = 8'h03;
  localparam logic [7:0] CMD_RIGHT    = 8'h04;
  localparam logic [7:0] CMD_AUTO_ON  = 8'h05;
  localparam logic [7:0] CMD_AUTO_OFF = 8'h06;

  typedef enum logic [2:0] {
    MOT_STOP  = 3'd0,
    MOT_FWD   = 3'd1,
    MOT_BACK  = 3'd2,
    MOT_LEFT  = 3'd3,
    MOT_RIGHT = 3'd4
  } motion_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GOT_HDR,
    ST_GOT_CMD,
    ST_GOT_SPD
  } state_e;

  function automatic logic cmd_is_valid(input logic [7:0] cmd);
    return cmd <= CMD_AUTO_OFF;
  endfunction

endpackage

// File: rtl/bt_timeout_cnt.sv
// Clear/enable cycle counter that pulses tc_o on the edge where it reaches
// LIMIT-1; optionally saturates there so the pulse is one-shot.
module bt_timeout_cnt #(
  parameter int unsigned LIMIT    = 1000,
  parameter bit          SATURATE = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned W = (LIMIT > 2) ? $clog2(LIMIT) : 1;
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);
  localparam logic [W-1:0] PRE  = W'(LIMIT - 2);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      if (cnt_q == LAST) begin
        cnt_d = SATURATE ? LAST : '0;
      end else begin
        cnt_d = cnt_q + W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A clear in the same cycle always beats expiry.
  assign tc_o = en_i && !clr_i && (cnt_q == PRE);

endmodule

// File: rtl/bt_cmd_decoder.sv
// Parses 4-byte HDR/CMD/SPD/CHK frames from the UART byte stream into
// registered motion/speed/mode outputs, with byte timeout and link watchdog.
module bt_cmd_decoder
  import bt_cmd_decoder_pkg::*;
#(
  parameter logic [7:0]  HDR_BYTE     = HDR_BYTE_DEF,
  parameter int unsigned BYTE_TIMEOUT = 1000000,
  parameter int unsigned LINK_TIMEOUT = 50000000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RX_vld,
  input  logic [7:0] RXData,
  output logic [2:0] motion,
  output logic [7:0] speed,
  output logic       auto_mode,
  output logic       cmd_vld,
  output logic       frame_err,
  output logic       link_ok
);

  state_e     state_q, state_d;
  logic [7:0] cmd_q, cmd_d;
  logic [7:0] spd_q, spd_d;
  motion_e    motion_q, motion_d;
  logic [7:0] speed_q, speed_d;
  logic       auto_q, auto_d;
  logic       cmd_vld_q, cmd_vld_d;
  logic       frame_err_q, frame_err_d;
  logic       link_ok_q, link_ok_d;

  logic accept;
  logic byte_tc;
  logic link_tc;

  // Kept outside the main comb block so the watchdog clear has no false loop.
  assign accept = (state_q == ST_GOT_SPD) && RX_vld &&
                  (RXData == (cmd_q ^ spd_q)) && cmd_is_valid(cmd_q);

  bt_timeout_cnt #(
    .LIMIT   (BYTE_TIMEOUT),
    .SATURATE(1'b0)
  ) u_byte_to (
    .clk_i(CLK),
    .rst_i(RST),
    .clr_i(RX_vld || (state_q == ST_IDLE)),
    .en_i (state_q != ST_IDLE),
    .tc_o (byte_tc)
  );

  bt_timeout_cnt #(
    .LIMIT   (LINK_TIMEOUT),
    .SATURATE(1'b1)
  ) u_link_wd (
    .clk_i(CLK),
    .rst_i(RST),
    .clr_i(accept),
    .en_i (1'b1),
    .tc_o (link_tc)
  );

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    spd_d       = spd_q;
    motion_d    = motion_q;
    speed_d     = speed_q;
    auto_d      = auto_q;
    link_ok_d   = link_ok_q;
    cmd_vld_d   = 1'b0;
    frame_err_d = 1'b0;

    if (byte_tc) begin
      state_d     = ST_IDLE;
      frame_err_d = 1'b1;
    end else if (RX_vld) begin
      case (state_q)
        ST_IDLE:    if (RXData == HDR_BYTE) state_d = ST_GOT_HDR;
        ST_GOT_HDR: begin
          cmd_d   = RXData;
          state_d = ST_GOT_CMD;
        end
        ST_GOT_CMD: begin
          spd_d   = RXData;
          state_d = ST_GOT_SPD;
        end
        default: begin
          state_d     = ST_IDLE;
          frame_err_d = !accept;
        end
      endcase
    end

    if (accept) begin
      cmd_vld_d = 1'b1;
      link_ok_d = 1'b1;
      case (cmd_q)
        CMD_STOP: begin
          motion_d = MOT_STOP;
          speed_d  = 8'h00;
        end
        CMD_FWD, CMD_BACK, CMD_LEFT, CMD_RIGHT: begin
          motion_d = motion_e'(cmd_q[2:0]);
          speed_d  = spd_q;
        end
        CMD_AUTO_ON:  auto_d = 1'b1;
        CMD_AUTO_OFF: auto_d = 1'b0;
        default: ;
      endcase
    end else if (link_tc) begin
      motion_d  = MOT_STOP;
      speed_d   = 8'h00;
      auto_d    = 1'b0;
      link_ok_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      cmd_q       <= 8'h00;
      spd_q       <= 8'h00;
      motion_q    <= MOT_STOP;
      speed_q     <= 8'h00;
      auto_q      <= 1'b0;
      cmd_vld_q   <= 1'b0;
      frame_err_q <= 1'b0;
      link_ok_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      spd_q       <= spd_d;
      motion_q    <= motion_d;
      speed_q     <= speed_d;
      auto_q      <= auto_d;
      cmd_vld_q   <= cmd_vld_d;
      frame_err_q <= frame_err_d;
      link_ok_q   <= link_ok_d;
    end
  end

  assign motion    = motion_q;
  assign speed     = speed_q;
  assign auto_mode = auto_q;
  assign cmd_vld   = cmd_vld_q;
  assign frame_err = frame_err_q;
  assign link_ok   = link_ok_q;

endmodule

// File: tb/tb_bt_cmd_decoder.sv
// Directed bench for bt_cmd_decoder with shortened timeouts; every expected
// value below is hand-computed from the frame format and timeout rules.
module tb_bt_cmd_decoder;

  localparam int unsigned BYTE_TO = 40;
  localparam int unsigned LINK_TO = 1000;

  logic       CLK;
  logic       RST;
  logic       RX_vld;
  logic [7:0] RXData;
  logic [2:0] motion;
  logic [7:0] speed;
  logic       auto_mode;
  logic       cmd_vld;
  logic       frame_err;
  logic       link_ok;

  int n_checks = 0;
  int n_fail   = 0;

  bt_cmd_decoder #(
    .HDR_BYTE    (8'hA5),
    .BYTE_TIMEOUT(BYTE_TO),
    .LINK_TIMEOUT(LINK_TO)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .RX_vld   (RX_vld),
    .RXData   (RXData),
    .motion   (motion),
    .speed    (speed),
    .auto_mode(auto_mode),
    .cmd_vld  (cmd_vld),
    .frame_err(frame_err),
    .link_ok  (link_ok)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Byte strobe straddles exactly one rising edge; returns on the following
  // falling edge, when the registered response to that byte is visible.
  task automatic send_byte(input logic [7:0] b);
    @(negedge CLK);
    RX_vld = 1'b1;
    RXData = b;
    @(negedge CLK);
    RX_vld = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] h, input logic [7:0] c,
                            input logic [7:0] s, input logic [7:0] k);
    send_byte(h);
    send_byte(c);
    send_byte(s);
    send_byte(k);
    $display("frame %h %h %h %h -> motion=%0d speed=%h auto=%0b vld=%0b err=%0b link=%0b",
             h, c, s, k, motion, speed, auto_mode, cmd_vld, frame_err, link_ok);
  endtask

  task automatic check_outputs(input string tag, input logic [2:0] m, input logic [7:0] s,
                               input logic a, input logic v, input logic e, input logic l);
    check({tag, ".motion"}, 32'(motion), 32'(m));
    check({tag, ".speed"}, 32'(speed), 32'(s));
    check({tag, ".auto"}, 32'(auto_mode), 32'(a));
    check({tag, ".cmd_vld"}, 32'(cmd_vld), 32'(v));
    check({tag, ".frame_err"}, 32'(frame_err), 32'(e));
    check({tag, ".link_ok"}, 32'(link_ok), 32'(l));
  endtask

  initial begin
    int hit;
    RST    = 1'b1;
    RX_vld = 1'b0;
    RXData = 8'h00;
    repeat (3) @(negedge CLK);
    check_outputs("reset", 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    RST = 1'b0;

    // Basic accepted forward frame, then cmd_vld drops after one cycle.
    send_frame(8'hA5, 8'h01, 8'h80, 8'h81);
    check_outputs("fwd", 3'd1, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1);
    @(negedge CLK);
    check("fwd.vld_pulse", 32'(cmd_vld), 32'd0);

    // Bad checksum: error pulse, outputs held; next frame still parses.
    send_frame(8'hA5, 8'h03, 8'h40, 8'h47);
    check_outputs("badchk", 3'd1, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1);
    send_frame(8'hA5, 8'h04, 8'h40, 8'h44);
    check_outputs("right", 3'd4, 8'h40, 1'b0, 1'b1, 1'b0, 1'b1);

    // Inter-byte timeout: counter reaches BYTE_TO-1 on the 39th idle edge.
    send_byte(8'hA5);
    send_byte(8'h01);
    hit = -1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge CLK);
      if (frame_err) begin
        hit = i;
        break;
      end
    end
    $display("byte timeout: frame_err after %0d idle cycles", hit);
    check("byteto.cycles", 32'(hit), 32'(BYTE_TO - 1));
    check("byteto.motion", 32'(motion), 32'd4);
    @(negedge CLK);
    check("byteto.pulse", 32'(frame_err), 32'd0);
    send_frame(8'hA5, 8'h02, 8'h20, 8'h22);
    check_outputs("back", 3'd2, 8'h20, 1'b0, 1'b1, 1'b0, 1'b1);

    // Byte landing exactly on the expiry edge is kept.
    send_byte(8'hA5);
    repeat (BYTE_TO - 3) @(negedge CLK);
    send_byte(8'h01);
    send_byte(8'h10);
    send_byte(8'h11);
    $display("expiry-edge frame -> motion=%0d speed=%h vld=%0b", motion, speed, cmd_vld);
    check_outputs("edgebyte", 3'd1, 8'h10, 1'b0, 1'b1, 1'b0, 1'b1);

    // Auto mode then watchdog expiry at LINK_TO-1 cycles after last accept.
    send_frame(8'hA5, 8'h05, 8'h00, 8'h05);
    check_outputs("auto_on", 3'd1, 8'h10, 1'b1, 1'b1, 1'b0, 1'b1);
    send_frame(8'hA5, 8'h01, 8'hFF, 8'hFE);
    check_outputs("fwd_ff", 3'd1, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b1);
    hit = -1;
    for (int i = 1; i <= 1100; i++) begin
      @(negedge CLK);
      if (!link_ok) begin
        hit = i;
        break;
      end
    end
    $display("link watchdog: link_ok dropped after %0d cycles", hit);
    check("linkwd.cycles", 32'(hit), 32'(LINK_TO - 1));
    check_outputs("linkwd", 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    // Noise in IDLE is silent; an invalid command code is rejected.
    send_frame(8'hA5, 8'h03, 8'h33, 8'h30);
    check_outputs("left", 3'd3, 8'h33, 1'b0, 1'b1, 1'b0, 1'b1);
    send_byte(8'h00);
    check("noise00.err", 32'(frame_err), 32'd0);
    send_byte(8'hFF);
    check("noiseFF.err", 32'(frame_err), 32'd0);
    send_byte(8'h13);
    check("noise13.err", 32'(frame_err), 32'd0);
    send_frame(8'hA5, 8'h07, 8'h00, 8'h07);
    check_outputs("badcmd", 3'd3, 8'h33, 1'b0, 1'b0, 1'b1, 1'b1);

    // Reset mid-frame drops the partial frame without an error pulse.
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h80);
    RST = 1'b1;
    @(negedge CLK);
    check_outputs("midrst", 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    RST = 1'b0;
    send_byte(8'h81);
    check_outputs("postrst", 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'hA5, 8'h04, 8'h7F, 8'h7B);
    check_outputs("rst_right", 3'd4, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
